// File: rtl/uart_rx_path.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at mid-period
// and reports good bytes with a one-cycle valid strobe and bad stop bits as frame errors.
module uart_rx_path #(
  parameter int unsigned FREQ       = 90,
  parameter int unsigned BAUD       = 57600,
  parameter logic [15:0] BAUD_TICKS = 16'((FREQ * 1000 * 1000) / BAUD - 1),
  parameter logic [15:0] HALF_TICKS = BAUD_TICKS / 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_valid_o,
  output logic       frame_err_o,
  output logic       bussy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        sync1_q;
  logic        rx_s_q;

  // Two-flop synchroniser; resets to the idle line level so no false start is seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      // Re-check the start bit at its middle so short glitches are rejected.
      START: begin
        if (cnt_q == HALF_TICKS) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == BAUD_TICKS) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s_q;
          idx_d          = 3'(idx_q + 3'd1);
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Leaving at mid-stop-bit gives half a bit of slack for a back-to-back start edge.
      STOP: begin
        if (cnt_q == BAUD_TICKS) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // A line held low after a bad stop bit must not be mistaken for a new start bit.
      BRK: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign uart_rx_data_o  = data_q;
  assign uart_rx_valid_o = valid_q;
  assign frame_err_o     = ferr_q;
  assign bussy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_path.sv
// Bench for uart_rx_path: directed scenarios plus random frames, scored against a
// queue of expected strobes derived from the line timing (start edge + fixed latency).
module tb_uart_rx_path;

  localparam int unsigned FREQ    = 1;
  localparam int unsigned BAUD    = 100000;
  localparam int unsigned BIT_CYC = (FREQ * 1000000) / BAUD;
  localparam int unsigned HALF    = (BIT_CYC - 1) / 2;
  localparam int unsigned LAT     = 2 + 1 + HALF + 9 * BIT_CYC + 1;

  typedef struct {
    bit          err;
    logic [7:0]  data;
    int unsigned at;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [7:0]  data;
  logic        valid;
  logic        ferr;
  logic        bussy;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  ev_t         exp_q[$];
  ev_t         mon_ev;
  logic [7:0]  model_data = 8'h00;

  uart_rx_path #(
    .FREQ(FREQ),
    .BAUD(BAUD)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .uart_rx_i      (rx),
    .uart_rx_data_o (data),
    .uart_rx_valid_o(valid),
    .frame_err_o    (ferr),
    .bussy          (bussy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame starting right now; records the strobe the frame must produce.
  task automatic send_frame(input logic [7:0] b, input bit good_stop);
    ev_t e;
    e.err  = !good_stop;
    e.data = b;
    e.at   = cyc + LAT;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(BIT_CYC);
    end
    rx = good_stop;
    wait_cyc(BIT_CYC);
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    rx  = 1'b1;
    exp_q.delete();
    model_data = 8'h00;
    wait_cyc(n);
    rst = 1'b0;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_bussy", bussy, 1'b0);
  endtask

  // Scoreboard: every strobe must match the head of the expectation queue in kind and cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        chk("missed_event", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      chk("strobe_excl", valid & ferr, 1'b0);
      if (valid || ferr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {valid, ferr}, 2'b00);
        end else begin
          mon_ev = exp_q.pop_front();
          chk("strobe_kind", ferr, mon_ev.err);
          chk("strobe_time", cyc, mon_ev.at);
          if (valid && !mon_ev.err) begin
            model_data = mon_ev.data;
            chk("valid_data", data, mon_ev.data);
            chk("bussy_at_valid", bussy, 1'b0);
          end
        end
      end
      chk("data_hold", data, model_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    bit         good;

    wait_cyc(1);
    do_reset(3);

    // Idle line: nothing happens.
    for (int i = 0; i < 50; i++) begin
      wait_cyc(1);
      chk("idle_bussy", bussy, 1'b0);
    end
    chk("idle_data", data, 8'h00);

    send_frame(8'hA5, 1'b1);
    wait_cyc(20);
    chk("a5_data", data, 8'hA5);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(20);
    chk("b2b_data", data, 8'hFF);

    // Short low glitch is rejected by the mid-start check.
    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(20);
    chk("glitch_bussy", bussy, 1'b0);

    // Bad stop, then a long break that must not start a new frame.
    send_frame(8'h3C, 1'b0);
    wait_cyc(40);
    chk("break_bussy", bussy, 1'b1);
    rx = 1'b1;
    wait_cyc(5);
    chk("after_break_bussy", bussy, 1'b0);
    send_frame(8'h81, 1'b1);
    wait_cyc(20);
    chk("after_break_data", data, 8'h81);

    // Reset in the middle of the data bits of 8'h5A.
    b  = 8'h5A;
    rx = 1'b0;
    wait_cyc(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cyc(BIT_CYC);
    end
    chk("mid_frame_bussy", bussy, 1'b1);
    do_reset(3);
    wait_cyc(5);
    send_frame(8'hC3, 1'b1);
    wait_cyc(20);
    chk("post_reset_data", data, 8'hC3);

    // Random frames with random gaps and occasional framing errors.
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 99) >= 15);
      send_frame(b, good);
      if (!good) begin
        wait_cyc($urandom_range(0, 30));
        rx = 1'b1;
        wait_cyc($urandom_range(3, 12));
      end else begin
        wait_cyc($urandom_range(0, 20));
      end
    end

    wait_cyc(LAT + 20);
    chk("drain", exp_q.size(), 0);
    chk("final_bussy", bussy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
